// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: holds the bus during init, then grants it to auto-refresh,
// the write client or the read client one at a time, and schedules periodic refresh.
module sdram_arbit #(
    parameter int REF_PERIOD = 390,
    parameter int T_RFC      = 7
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic        flag_init_end,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        flag_wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        flag_rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        ref_req,
    output logic        ref_ovf,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [4:0] {
        S_INIT  = 5'b00001,
        S_ARBIT = 5'b00010,
        S_AREF  = 5'b00100,
        S_WRITE = 5'b01000,
        S_READ  = 5'b10000
    } state_t;

    state_t      state;
    logic [9:0]  ref_timer;
    logic [2:0]  aref_cnt;
    logic        last_wr;
    logic        ref_wrap;
    logic        aref_entry;

    assign ref_wrap   = (state != S_INIT) && (ref_timer == 10'(REF_PERIOD - 1));
    assign aref_entry = (state == S_ARBIT) && ref_req;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= S_INIT;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            aref_cnt <= 3'd0;
            last_wr  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                S_INIT: begin
                    if (flag_init_end)
                        state <= S_ARBIT;
                end
                S_ARBIT: begin
                    // Refresh first; on a tie the client that did not win last time goes.
                    if (ref_req) begin
                        state    <= S_AREF;
                        aref_cnt <= 3'd0;
                    end else if (wr_req && (!rd_req || !last_wr)) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        last_wr <= 1'b1;
                    end else if (rd_req) begin
                        state   <= S_READ;
                        rd_en   <= 1'b1;
                        last_wr <= 1'b0;
                    end
                end
                S_AREF: begin
                    if (aref_cnt == 3'(T_RFC - 1)) begin
                        state    <= S_ARBIT;
                        aref_cnt <= 3'd0;
                    end else begin
                        aref_cnt <= aref_cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (flag_wr_end)
                        state <= S_ARBIT;
                end
                S_READ: begin
                    if (flag_rd_end)
                        state <= S_ARBIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // A wrap coinciding with the AREF entry re-arms the request and is not an overflow.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            ref_timer <= 10'd0;
            ref_req   <= 1'b0;
            ref_ovf   <= 1'b0;
        end else begin
            if (state == S_INIT || ref_wrap)
                ref_timer <= 10'd0;
            else
                ref_timer <= ref_timer + 10'd1;

            if (ref_wrap)
                ref_req <= 1'b1;
            else if (aref_entry)
                ref_req <= 1'b0;

            if (ref_wrap && ref_req && !aref_entry)
                ref_ovf <= 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 13'd0;
        sdram_bank = 2'd0;
        case (state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            S_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            S_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            S_AREF: begin
                sdram_cmd = (aref_cnt == 3'd0) ? CMD_AREF : CMD_NOP;
            end
            default: ;
        endcase
    end

    assign sdram_dq_out = wr_data;
    assign sdram_dq_oe  = (state == S_WRITE);

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: stimulus pushes expected bus events (grants, AREF) into a queue,
// a negedge monitor pops and compares them; timing and reset behaviour checked directly.
module tb_sdram_arbit;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        flag_init_end;
    logic        wr_req, wr_en, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        rd_req, rd_en, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        ref_req, ref_ovf;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    sdram_arbit #(.REF_PERIOD(390), .T_RFC(7)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
        .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_req(ref_req), .ref_ovf(ref_ovf),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sclk = ~sclk;

    typedef enum logic [1:0] {EV_WR = 2'd0, EV_RD = 2'd1, EV_AREF = 2'd2} ev_t;
    ev_t exp_q[$];
    ev_t got_e, exp_e;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return wr_en;
            1:       return rd_en;
            2:       return ref_req;
            3:       return ref_ovf;
            default: return wr_en | rd_en;
        endcase
    endfunction

    // Bounded wait: the final value of the awaited signal is itself a counted comparison.
    task automatic wait_for(input int which, input int budget, input string name);
        logic s;
        s = 1'b0;
        for (int i = 0; i < budget && !s; i++) begin
            tick();
            s = sel(which);
        end
        check(name, {31'd0, s}, 32'd1);
    endtask

    always @(negedge sclk) begin
        if (mon_en && (wr_en || rd_en || sdram_cmd == 4'b0001)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL mon_unexpected: wr_en=%0b rd_en=%0b cmd=%b with empty queue",
                         wr_en, rd_en, sdram_cmd);
            end else begin
                got_e = wr_en ? EV_WR : (rd_en ? EV_RD : EV_AREF);
                exp_e = exp_q.pop_front();
                check("mon_event", 32'(got_e), 32'(exp_e));
                case (got_e)
                    EV_WR: begin
                        check("mon_wr_cmd",  32'(sdram_cmd),  32'(wr_cmd));
                        check("mon_wr_addr", 32'(sdram_addr), 32'(wr_addr));
                        check("mon_wr_bank", 32'(sdram_bank), 32'(wr_bank));
                        check("mon_wr_oe",   32'(sdram_dq_oe), 32'd1);
                    end
                    EV_RD: begin
                        check("mon_rd_cmd",  32'(sdram_cmd),  32'(rd_cmd));
                        check("mon_rd_addr", 32'(sdram_addr), 32'(rd_addr));
                        check("mon_rd_bank", 32'(sdram_bank), 32'(rd_bank));
                        check("mon_rd_oe",   32'(sdram_dq_oe), 32'd0);
                    end
                    default: begin
                        check("mon_aref_addr", 32'(sdram_addr), 32'd0);
                        check("mon_aref_bank", 32'(sdram_bank), 32'd0);
                    end
                endcase
            end
        end
    end

    int c0, a, r, nops;

    initial begin
        s_rst_n = 1'b0;
        init_cmd = 4'b0010; init_addr = 13'h0400; flag_init_end = 1'b0;
        wr_req = 1'b0; flag_wr_end = 1'b0;
        wr_cmd = 4'b0100; wr_addr = 13'h0123; wr_bank = 2'd2; wr_data = 16'hBEEF;
        rd_req = 1'b0; flag_rd_end = 1'b0;
        rd_cmd = 4'b0101; rd_addr = 13'h00AB; rd_bank = 2'd1;

        // Reset state
        repeat (3) tick();
        check("rst_wr_en",   32'(wr_en), 32'd0);
        check("rst_rd_en",   32'(rd_en), 32'd0);
        check("rst_ref_req", 32'(ref_req), 32'd0);
        check("rst_ref_ovf", 32'(ref_ovf), 32'd0);
        check("rst_cmd",     32'(sdram_cmd), 32'h2);
        check("rst_addr",    32'(sdram_addr), 32'h400);
        check("rst_bank",    32'(sdram_bank), 32'd0);
        check("rst_oe",      32'(sdram_dq_oe), 32'd0);
        s_rst_n = 1'b1;

        // Init handoff after 100 cycles
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 50) begin
                init_cmd = 4'b0000; init_addr = 13'h0032;
                #1;
                check("init_mirror_cmd",  32'(sdram_cmd), 32'h0);
                check("init_mirror_addr", 32'(sdram_addr), 32'h32);
            end
        end
        flag_init_end = 1'b1;
        tick();
        flag_init_end = 1'b0;
        c0 = cyc;
        mon_en = 1'b1;
        check("arbit_cmd",  32'(sdram_cmd), 32'h7);
        check("arbit_addr", 32'(sdram_addr), 32'd0);
        check("arbit_bank", 32'(sdram_bank), 32'd0);
        check("arbit_oe",   32'(sdram_dq_oe), 32'd0);

        // Single write
        exp_q.push_back(EV_WR);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        check("wr_en_first", 32'(wr_en), 32'd1);
        tick();
        check("wr_en_one_cycle", 32'(wr_en), 32'd0);
        check("wr_oe_held", 32'(sdram_dq_oe), 32'd1);
        repeat (3) tick();
        wr_addr = 13'h0555;
        flag_wr_end = 1'b1;
        #1;
        check("wr_release_addr", 32'(sdram_addr), 32'h555);
        tick();
        flag_wr_end = 1'b0;
        check("wr_done_oe",   32'(sdram_dq_oe), 32'd0);
        check("wr_done_cmd",  32'(sdram_cmd), 32'h7);
        check("wr_done_addr", 32'(sdram_addr), 32'd0);
        check("dq_out_idle",  32'(sdram_dq_out), 32'hBEEF);

        // First refresh while idle, with a read waiting behind it
        wait_for(2, 400, "ref_req_rise");
        check("ref_period", 32'(cyc - c0), 32'd390);
        exp_q.push_back(EV_AREF);
        exp_q.push_back(EV_RD);
        rd_req = 1'b1;
        tick();
        a = cyc;
        check("ref_req_cleared", 32'(ref_req), 32'd0);
        check("aref_cmd", 32'(sdram_cmd), 32'h1);
        nops = 0;
        repeat (6) begin
            tick();
            if (sdram_cmd == 4'b0111) nops++;
        end
        check("aref_nops", 32'(nops), 32'd6);
        wait_for(1, 20, "rd_after_aref");
        check("aref_to_rd_latency", 32'(cyc - a), 32'd8);
        rd_req = 1'b0;
        repeat (2) tick();
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        check("rd_done_cmd", 32'(sdram_cmd), 32'h7);

        // Tie fairness: W,R,W,R; both end flags pulsed so the wrong one must be ignored
        exp_q.push_back(EV_WR); exp_q.push_back(EV_RD);
        exp_q.push_back(EV_WR); exp_q.push_back(EV_RD);
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_for(4, 20, "tie_grant");
            if (k == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
            repeat (10) tick();
            flag_wr_end = 1'b1; flag_rd_end = 1'b1;
            tick();
            flag_wr_end = 1'b0; flag_rd_end = 1'b0;
        end
        check("tie_queue_drained", 32'(exp_q.size()), 32'd0);

        // Refresh interrupting a write, ahead of a pending read
        exp_q.push_back(EV_WR);
        wr_req = 1'b1;
        wait_for(0, 20, "irq_wr_grant");
        wr_req = 1'b0;
        wait_for(2, 400, "irq_ref_req");
        check("irq_ref_time", 32'(cyc - c0), 32'd780);
        check("irq_in_write", 32'(sdram_dq_oe), 32'd1);
        check("irq_no_ovf",   32'(ref_ovf), 32'd0);
        exp_q.push_back(EV_AREF);
        exp_q.push_back(EV_RD);
        rd_req = 1'b1;
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        r = cyc;
        wait_for(1, 20, "irq_rd_grant");
        check("irq_release_to_rd", 32'(cyc - r), 32'd9);
        rd_req = 1'b0;
        repeat (3) tick();
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;

        // Long write: refresh pending, then overflow
        exp_q.push_back(EV_WR);
        wr_req = 1'b1;
        wait_for(0, 20, "ovf_wr_grant");
        wr_req = 1'b0;
        wait_for(2, 500, "ovf_ref_req");
        check("ovf_ref_time", 32'(cyc - c0), 32'd1170);
        check("ovf_not_yet",  32'(ref_ovf), 32'd0);
        wait_for(3, 500, "ovf_set");
        check("ovf_time", 32'(cyc - c0), 32'd1560);
        repeat (20) tick();
        check("ovf_sticky",   32'(ref_ovf), 32'd1);
        check("ovf_ref_held", 32'(ref_req), 32'd1);
        check("ovf_still_wr", 32'(sdram_dq_oe), 32'd1);

        // Asynchronous reset mid-write
        #2;
        s_rst_n = 1'b0;
        #1;
        check("mid_rst_ovf",  32'(ref_ovf), 32'd0);
        check("mid_rst_req",  32'(ref_req), 32'd0);
        check("mid_rst_wren", 32'(wr_en), 32'd0);
        check("mid_rst_oe",   32'(sdram_dq_oe), 32'd0);
        check("mid_rst_cmd",  32'(sdram_cmd), 32'(init_cmd));
        check("mid_rst_addr", 32'(sdram_addr), 32'(init_addr));
        tick();
        s_rst_n = 1'b1;
        wr_req = 1'b1;
        repeat (20) tick();
        check("init_ignores_req_oe",  32'(sdram_dq_oe), 32'd0);
        check("init_ignores_req_cmd", 32'(sdram_cmd), 32'(init_cmd));
        wr_req = 1'b0;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

SDRAM command-bus arbiter and refresh scheduler. Sits between the SDRAM pins and the initialisation, write (`sdram_write`) and read client blocks. It holds the bus for the init sequence, then grants exclusive ownership to one owner at a time: auto-refresh, write or read. It generates the periodic refresh request itself and multiplexes command, address, bank and write-data onto the pins.

## Interface
Parameters:
- `REF_PERIOD`, 390: cycles between refresh requests (7.8 µs at 50 MHz); 10-bit timer.
- `T_RFC`, 7: cycles the arbiter owns the bus for one AREF, including the AREF cycle.

Ports:
- `sclk` in 1: clock.
- `s_rst_n` in 1: reset, asynchronous, active-low.
- `init_cmd` in 4: command from the init block.
- `init_addr` in 13: address from the init block.
- `flag_init_end` in 1: init sequence done (level or pulse).
- `wr_req` in 1: write client wants the bus.
- `wr_en` out 1: write grant pulse.
- `flag_wr_end` in 1: write client released the bus (1-cycle pulse).
- `wr_cmd`, `wr_addr`, `wr_bank`, `wr_data` in 4/13/2/16: write client bus.
- `rd_req`, `rd_en`, `flag_rd_end`: read client; same semantics as write.
- `rd_cmd`, `rd_addr`, `rd_bank` in 4/13/2: read client bus.
- `ref_req` out 1: refresh pending; broadcast to both clients.
- `ref_ovf` out 1: sticky; a refresh period expired while `ref_req` was still pending.
- `sdram_cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `sdram_addr` out 13: pin address.
- `sdram_bank` out 2: pin bank address.
- `sdram_dq_out` out 16: pin write data.
- `sdram_dq_oe` out 1: DQ output enable.

## Operation
- One-hot state: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. Reset state is S_INIT.
- S_INIT → S_ARBIT when `flag_init_end` = 1. Otherwise stay.
- S_ARBIT priority:
  - `ref_req` is highest: go to S_AREF.
  - Otherwise, if only one of `wr_req`/`rd_req` is set, grant it.
  - If both are set, round-robin using a `last_wr` bit, set on every write grant and cleared on every read grant. If `last_wr` = 1, read wins; otherwise write wins. `last_wr` resets to 0, so write wins the first tie.
- S_WRITE → S_ARBIT on `flag_wr_end`. S_READ → S_ARBIT on `flag_rd_end`. No timeout.
- S_AREF:
  - A 3-bit `aref_cnt` counts 0..T_RFC-1 and returns to S_ARBIT when it reaches T_RFC-1.
  - `sdram_cmd` = AREF (0001) when `aref_cnt` = 0, else NOP (0111).
- Refresh timer:
  - Held at 0 in S_INIT. Otherwise counts every cycle and wraps from REF_PERIOD-1 to 0.
  - On wrap, `ref_req` is set. `ref_req` clears in the first cycle of S_AREF.
  - If a wrap occurs while `ref_req` = 1, `ref_ovf` is set and stays set until reset.
- Pin mux (combinational on state):
  - S_INIT: init_cmd/init_addr, bank 0.
  - S_WRITE: wr_* signals.
  - S_READ: rd_* signals.
  - S_AREF: own command, addr 0, bank 0.
  - S_ARBIT: NOP, 0, 0.
- `sdram_dq_oe` = (state == S_WRITE). `sdram_dq_out` = `wr_data` in every state.
- `flag_wr_end`/`flag_rd_end` are ignored outside the matching state. `wr_req`/`rd_req` are ignored outside S_ARBIT.

## Timing
- Reset values:
  - Registered outputs: `wr_en`, `rd_en`, `ref_req`, `ref_ovf` = 0.
  - Internal: timer 0, `aref_cnt` 0, `last_wr` 0.
  - Muxed outputs follow S_INIT: `sdram_cmd` = `init_cmd`, `sdram_addr` = `init_addr`, `sdram_bank` = 0, `sdram_dq_oe` = 0.
- Grant latency: a request sampled in S_ARBIT at edge N puts the new state in effect from edge N+1.
- `wr_en`/`rd_en` are registered. Each is high for exactly the first cycle of S_WRITE/S_READ.
- At least one S_ARBIT cycle separates any two ownership periods.
- Release timing: the client's release cycle (`flag_*_end` = 1) is still muxed from that client. The next cycle is S_ARBIT with NOP on the pins.
- Refresh request timing:
  - `ref_req` rises the cycle after timer wrap.
  - A timer wrap in the same cycle as an S_ARBIT decision does not affect that decision; the decision uses registered `ref_req`.
- Refresh during a burst: the client sees `ref_req`, precharges and pulses `flag_*_end`. The arbiter then goes S_ARBIT → S_AREF. After T_RFC cycles the interrupted client re-arbitrates under round-robin.
- Refresh clear vs. wrap: if `ref_req` clears (S_AREF entry) in the same cycle as a wrap, the set wins and `ref_req` stays 1. `ref_ovf` is not set in this case.
- Asynchronous reset mid-operation returns to S_INIT immediately and all pins revert to the reset values above.

## Test plan
- Init handoff: hold `flag_init_end` = 0 for 100 cycles, so pins mirror `init_cmd`/`init_addr`. Pulse it: next cycle state is S_ARBIT, pins show 0111/0/0, timer starts at 0.
- Single write, REF_PERIOD = 390: assert `wr_req` → `wr_en` high for 1 cycle, `sdram_dq_oe` = 1, pins follow wr_*. Pulse `flag_wr_end` → `sdram_dq_oe` drops next cycle.
- Refresh:
  - 390 cycles after init end, `ref_req` = 1 while idle.
  - S_AREF issues 0001 once, then 6 NOPs (T_RFC = 7).
  - `ref_req` clears in the first AREF cycle.
- Tie fairness: hold `wr_req` and `rd_req` high and auto-return each end flag 10 cycles after grant. Grants must alternate W,R,W,R starting with W.
- Refresh interrupt: during a write, timer wraps. Client pulses `flag_wr_end` → S_ARBIT → S_AREF, ahead of a pending `rd_req` → then read granted.
- Overflow and reset:
  - Keep the write granted for more than 780 cycles → `ref_ovf` = 1 and stays set.
  - Assert `s_rst_n` = 0 mid-write → `ref_ovf`, `wr_en`, `ref_req` = 0, state S_INIT.
